// File: rtl/rotor_stepper.sv
// rotor_stepper
// Front stage of the Enigma datapath. It accepts one character per valid/ready
// handshake and steps a three-rotor bank using odometer stepping, including
// the middle-rotor double step. It then presents the character, the mode bit
// and the combined rotor offset in a single registered output slot.
//
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   load, init_pos_0..2 - load rotor start positions (values > 25 load as 0)
//   char_valid, char_in, encrypt_in, char_ready - input handshake
//   out_valid, out_ready                        - output slot handshake
//   char_out, encrypt_out, rotor_value          - output slot contents
//   pos_0, pos_1, pos_2                         - current rotor positions
module rotor_stepper #(
   parameter int NOTCH_0 = 16,
   parameter int NOTCH_1 = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [6:0] init_pos_0,
   input  logic [6:0] init_pos_1,
   input  logic [6:0] init_pos_2,
   input  logic       char_valid,
   input  logic [6:0] char_in,
   input  logic       encrypt_in,
   output logic       char_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [6:0] char_out,
   output logic       encrypt_out,
   output logic [6:0] rotor_value,
   output logic [6:0] pos_0,
   output logic [6:0] pos_1,
   output logic [6:0] pos_2
);

   localparam logic [6:0] NOTCH_0_C = 7'(NOTCH_0);
   localparam logic [6:0] NOTCH_1_C = 7'(NOTCH_1);

   // Advance one rotor position, wrapping 25 back to 0.
   function automatic logic [6:0] inc26(input logic [6:0] p);
      return (p >= 7'd25) ? 7'd0 : p + 7'd1;
   endfunction

   // Out-of-range start positions are loaded as 0.
   function automatic logic [6:0] clamp26(input logic [6:0] p);
      return (p > 7'd25) ? 7'd0 : p;
   endfunction

   // The sum of three positions is at most 75, so two conditional
   // subtractions are enough to reduce it modulo 26.
   function automatic logic [6:0] mod26(input logic [6:0] s);
      logic [6:0] r;
      r = s;
      if (r >= 7'd26) r = r - 7'd26;
      if (r >= 7'd26) r = r - 7'd26;
      return r;
   endfunction

   logic [6:0] pos0_q, pos1_q, pos2_q;
   logic [6:0] pos0_d, pos1_d, pos2_d;
   logic       valid_q, valid_d;
   logic [6:0] char_q, char_d;
   logic       enc_q, enc_d;
   logic [6:0] rv_q, rv_d;

   logic       accept;
   logic       step_mid, step_slow;
   logic [6:0] nxt0, nxt1, nxt2;

   assign char_ready = !valid_q || out_ready;
   assign accept     = char_valid && char_ready && !load;

   // Both notch tests use the pre-step positions. If the middle rotor sits on
   // its own notch, it steps together with the slow rotor (double step).
   assign step_slow = (pos1_q == NOTCH_1_C);
   assign step_mid  = (pos0_q == NOTCH_0_C) || step_slow;
   assign nxt0      = inc26(pos0_q);
   assign nxt1      = step_mid  ? inc26(pos1_q) : pos1_q;
   assign nxt2      = step_slow ? inc26(pos2_q) : pos2_q;

   always_comb begin
      pos0_d  = pos0_q;
      pos1_d  = pos1_q;
      pos2_d  = pos2_q;
      valid_d = valid_q;
      char_d  = char_q;
      enc_d   = enc_q;
      rv_d    = rv_q;
      if (load) begin
         // Load wins over any accept in the same cycle and drops the slot.
         pos0_d  = clamp26(init_pos_0);
         pos1_d  = clamp26(init_pos_1);
         pos2_d  = clamp26(init_pos_2);
         valid_d = 1'b0;
      end else if (accept) begin
         // Rotors step first, so the offset uses the new positions.
         pos0_d  = nxt0;
         pos1_d  = nxt1;
         pos2_d  = nxt2;
         valid_d = 1'b1;
         char_d  = char_in;
         enc_d   = encrypt_in;
         rv_d    = mod26(nxt0 + nxt1 + nxt2);
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pos0_q  <= 7'd0;
         pos1_q  <= 7'd0;
         pos2_q  <= 7'd0;
         valid_q <= 1'b0;
         char_q  <= 7'd0;
         enc_q   <= 1'b0;
         rv_q    <= 7'd0;
      end else begin
         pos0_q  <= pos0_d;
         pos1_q  <= pos1_d;
         pos2_q  <= pos2_d;
         valid_q <= valid_d;
         char_q  <= char_d;
         enc_q   <= enc_d;
         rv_q    <= rv_d;
      end
   end

   assign out_valid   = valid_q;
   assign char_out    = char_q;
   assign encrypt_out = enc_q;
   assign rotor_value = rv_q;
   assign pos_0       = pos0_q;
   assign pos_1       = pos1_q;
   assign pos_2       = pos2_q;

endmodule

// File: tb/tb_rotor_stepper.sv
module tb_rotor_stepper;

   logic       clock = 1'b0;
   logic       reset, load, char_valid, encrypt_in, out_ready;
   logic [6:0] init_pos_0, init_pos_1, init_pos_2, char_in;
   logic       char_ready, out_valid, encrypt_out;
   logic [6:0] char_out, rotor_value, pos_0, pos_1, pos_2;

   rotor_stepper #(.NOTCH_0(16), .NOTCH_1(4)) dut (
      .clock(clock), .reset(reset), .load(load),
      .init_pos_0(init_pos_0), .init_pos_1(init_pos_1), .init_pos_2(init_pos_2),
      .char_valid(char_valid), .char_in(char_in), .encrypt_in(encrypt_in),
      .char_ready(char_ready), .out_valid(out_valid), .out_ready(out_ready),
      .char_out(char_out), .encrypt_out(encrypt_out), .rotor_value(rotor_value),
      .pos_0(pos_0), .pos_1(pos_1), .pos_2(pos_2)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: rotor positions as plain integers plus the slot.
   int m_p[3];
   int m_ov, m_ch, m_enc, m_rv;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int clampv(input int v);
      return (v > 25) ? 0 : v;
   endfunction

   task automatic model_update();
      int old0, old1;
      if (reset) begin
         m_p[0] = 0; m_p[1] = 0; m_p[2] = 0;
         m_ov = 0; m_ch = 0; m_enc = 0; m_rv = 0;
      end else if (load) begin
         m_p[0] = clampv(int'(init_pos_0));
         m_p[1] = clampv(int'(init_pos_1));
         m_p[2] = clampv(int'(init_pos_2));
         m_ov = 0;
      end else if (char_valid && (m_ov == 0 || out_ready)) begin
         old0 = m_p[0];
         old1 = m_p[1];
         m_p[0] = (m_p[0] + 1) % 26;
         if (old0 == 16 || old1 == 4) m_p[1] = (m_p[1] + 1) % 26;
         if (old1 == 4) m_p[2] = (m_p[2] + 1) % 26;
         m_ov = 1;
         m_ch = int'(char_in);
         m_enc = int'(encrypt_in);
         m_rv = (m_p[0] + m_p[1] + m_p[2]) % 26;
      end else if (m_ov == 1 && out_ready) begin
         m_ov = 0;
      end
   endtask

   // Inputs are already applied; check the combinational ready, clock once,
   // then check all registered outputs against the model.
   task automatic step();
      #1;
      if (!reset) chk("char_ready", int'(char_ready), (m_ov == 0 || out_ready) ? 1 : 0);
      @(posedge clock);
      model_update();
      #1;
      chk("pos_0", int'(pos_0), m_p[0]);
      chk("pos_1", int'(pos_1), m_p[1]);
      chk("pos_2", int'(pos_2), m_p[2]);
      chk("out_valid", int'(out_valid), m_ov);
      if (m_ov == 1) begin
         chk("char_out", int'(char_out), m_ch);
         chk("encrypt_out", int'(encrypt_out), m_enc);
         chk("rotor_value", int'(rotor_value), m_rv);
      end
   endtask

   task automatic do_load(input int a, input int b, input int c);
      load = 1'b1; char_valid = 1'b0;
      init_pos_0 = 7'(a); init_pos_1 = 7'(b); init_pos_2 = 7'(c);
      step();
      load = 1'b0;
   endtask

   task automatic send(input int ch, input int en, input int rdy);
      char_valid = 1'b1; char_in = 7'(ch); encrypt_in = en[0]; out_ready = rdy[0];
      step();
      char_valid = 1'b0;
   endtask

   int h0, h1, h2, hc, hr;

   initial begin
      reset = 1'b1; load = 1'b0; char_valid = 1'b1; char_in = 7'd5; encrypt_in = 1'b1;
      out_ready = 1'b1; init_pos_0 = 0; init_pos_1 = 0; init_pos_2 = 0;
      m_p[0] = 0; m_p[1] = 0; m_p[2] = 0; m_ov = 0; m_ch = 0; m_enc = 0; m_rv = 0;

      // Reset with char_valid held high.
      step(); step();
      chk("rst_char_out", int'(char_out), 0);
      chk("rst_rotor_value", int'(rotor_value), 0);
      chk("rst_encrypt_out", int'(encrypt_out), 0);
      reset = 1'b0; char_valid = 1'b0;
      #1 chk("rst_char_ready", int'(char_ready), 1);

      // Single step.
      do_load(0, 0, 0);
      send(7, 1, 1);
      chk("single_char", int'(char_out), 7);
      chk("single_enc", int'(encrypt_out), 1);
      chk("single_pos0", int'(pos_0), 1);
      chk("single_rv", int'(rotor_value), 1);

      // Notch and double step.
      do_load(16, 3, 0);
      send(65, 0, 1);
      chk("notch1_pos1", int'(pos_1), 4);
      chk("notch1_rv", int'(rotor_value), 21);
      send(66, 0, 1);
      chk("dbl_pos0", int'(pos_0), 18);
      chk("dbl_pos1", int'(pos_1), 5);
      chk("dbl_pos2", int'(pos_2), 1);
      chk("dbl_rv", int'(rotor_value), 24);

      // Wrap and modulo, out-of-range load.
      do_load(25, 25, 25);
      send(100, 1, 1);
      chk("wrap_pos0", int'(pos_0), 0);
      chk("wrap_pos1", int'(pos_1), 25);
      chk("wrap_rv", int'(rotor_value), 24);
      do_load(30, 0, 0);
      chk("clamp_pos0", int'(pos_0), 0);

      // Backpressure: fill the slot, then hold it for 5 cycles.
      do_load(3, 7, 9);
      send(10, 1, 0);
      h0 = int'(pos_0); h1 = int'(pos_1); h2 = int'(pos_2);
      hc = int'(char_out); hr = int'(rotor_value);
      char_valid = 1'b1; char_in = 7'd11; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_ready", int'(char_ready), 0);
         chk("bp_pos0", int'(pos_0), h0);
         chk("bp_char", int'(char_out), hc);
         chk("bp_rv", int'(rotor_value), hr);
      end
      out_ready = 1'b1;
      step();
      chk("bp_release_pos0", int'(pos_0), (h0 + 1) % 26);
      chk("bp_release_char", int'(char_out), 11);
      chk("bp_release_valid", int'(out_valid), 1);

      // Load priority while the slot is full.
      out_ready = 1'b0; char_valid = 1'b1;
      load = 1'b1; init_pos_0 = 7'd3; init_pos_1 = 7'd4; init_pos_2 = 7'd5;
      step();
      load = 1'b0; char_valid = 1'b0;
      chk("ldp_valid", int'(out_valid), 0);
      chk("ldp_pos0", int'(pos_0), 3);
      chk("ldp_pos1", int'(pos_1), 4);
      chk("ldp_pos2", int'(pos_2), 5);

      // Random traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         reset      = ($urandom_range(0, 63) == 0);
         load       = ($urandom_range(0, 15) == 0);
         init_pos_0 = 7'($urandom_range(0, 31));
         init_pos_1 = 7'($urandom_range(0, 31));
         init_pos_2 = 7'($urandom_range(0, 31));
         char_valid = ($urandom_range(0, 3) != 0);
         char_in    = 7'($urandom_range(0, 127));
         encrypt_in = 1'($urandom_range(0, 1));
         out_ready  = ($urandom_range(0, 2) != 0);
         step();
      end
      reset = 1'b0; load = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
